rect_plot_arbiter: RTL and testbench

RECT_PLOT_ARBITER -- requirements
Module: rect_plot_arbiter

---
 rtl/rect_plot_arbiter.sv | 160 ++++++++++++++++
 tb/tb_rect_plot_arbiter.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rect_plot_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rect_plot_arbiter: 3-way round-robin XDIM x YDIM rectangle plotter for vga_adapter.
// Optional macro RECT_CLIP_EN suppresses plot for pixels off the 160x120 frame. Rev 1.0
// ----------------------------------------------------------------------------
module rect_plot_arbiter #(
  parameter int XDIM = 10,
  parameter int YDIM = 10
) (
  input  logic        CLOCK_50,
  input  logic        Resetn,
  input  logic [2:0]  req,
  input  logic [23:0] req_x,
  input  logic [20:0] req_y,
  input  logic [8:0]  req_col,
  output logic [2:0]  grant,
  output logic [2:0]  done,
  output logic        busy,
  output logic [7:0]  VGA_X,
  output logic [6:0]  VGA_Y,
  output logic [2:0]  VGA_COLOR,
  output logic        plot
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DRAW = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [3:0] X_LAST = 4'(XDIM - 1);
  localparam logic [3:0] Y_LAST = 4'(YDIM - 1);

  logic [1:0] state, state_nxt;
  logic [1:0] win, last, pick, cand;
  logic [7:0] bx, last_x, sum_x;
  logic [6:0] by, last_y, sum_y;
  logic [2:0] col, last_col, win_oh;
  logic [3:0] xc, yc;
  logic       row_end, last_pixel, in_frame;

  logic [7:0] lane_x [4];
  logic [6:0] lane_y [4];
  logic [2:0] lane_c [4];

  generate
    for (genvar i = 0; i < 3; i++) begin : g_unpack
      assign lane_x[i] = req_x[8*i +: 8];
      assign lane_y[i] = req_y[7*i +: 7];
      assign lane_c[i] = req_col[3*i +: 3];
    end
  endgenerate
  assign lane_x[3] = '0;
  assign lane_y[3] = '0;
  assign lane_c[3] = '0;

  // Walk from lowest to highest priority so the highest-priority requester overwrites.
  always_comb begin
    pick = last;
    cand = '0;
    for (int k = 3; k >= 1; k--) begin
      cand = 2'((32'(last) + 32'(k)) % 32'd3);
      if (req[cand]) pick = cand;
    end
  end

  assign sum_x      = bx + {4'b0000, xc};
  assign sum_y      = by + {3'b000, yc};
  assign row_end    = (xc == X_LAST);
  assign last_pixel = row_end && (yc == Y_LAST);
  assign win_oh     = 3'b001 << win;

`ifdef RECT_CLIP_EN
  logic [8:0] wide_x;
  logic [7:0] wide_y;
  assign wide_x   = {1'b0, bx} + {5'b00000, xc};
  assign wide_y   = {1'b0, by} + {4'b0000, yc};
  assign in_frame = (wide_x <= 9'd159) && (wide_y <= 8'd119);
`else
  assign in_frame = 1'b1;
`endif

  always_ff @(posedge CLOCK_50) begin
    if (!Resetn) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (req != 3'b000) state_nxt = S_DRAW;
      S_DRAW:  if (last_pixel)    state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // last resets to 2 so requester 0 is first in line after reset.
  always_ff @(posedge CLOCK_50) begin
    if (!Resetn) begin
      xc       <= '0;
      yc       <= '0;
      win      <= '0;
      last     <= 2'd2;
      bx       <= '0;
      by       <= '0;
      col      <= '0;
      last_x   <= '0;
      last_y   <= '0;
      last_col <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req != 3'b000) begin
            win  <= pick;
            last <= pick;
            bx   <= lane_x[pick];
            by   <= lane_y[pick];
            col  <= lane_c[pick];
            xc   <= '0;
            yc   <= '0;
          end
        end
        S_DRAW: begin
          last_x   <= sum_x;
          last_y   <= sum_y;
          last_col <= col;
          if (row_end) begin
            xc <= '0;
            yc <= yc + 4'd1;
          end else begin
            xc <= xc + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    grant     = '0;
    done      = '0;
    plot      = 1'b0;
    busy      = (state != S_IDLE);
    VGA_X     = last_x;
    VGA_Y     = last_y;
    VGA_COLOR = last_col;
    case (state)
      S_DRAW: begin
        plot      = in_frame;
        VGA_X     = sum_x;
        VGA_Y     = sum_y;
        VGA_COLOR = col;
        if (xc == 4'd0 && yc == 4'd0) grant = win_oh;
      end
      S_DONE:  done = win_oh;
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_rect_plot_arbiter.sv
`default_nettype none
// Self-checking bench for rect_plot_arbiter: arbitration table, directed corner cases,
// and randomized traffic against a transaction-level reference model.
module tb_rect_plot_arbiter;

  localparam int XD   = 10;
  localparam int YD   = 10;
  localparam int NPIX = XD * YD;

  logic        CLOCK_50 = 1'b0;
  logic        Resetn;
  logic [2:0]  req;
  logic [23:0] req_x;
  logic [20:0] req_y;
  logic [8:0]  req_col;
  logic [2:0]  grant, done, VGA_COLOR;
  logic        busy, plot;
  logic [7:0]  VGA_X;
  logic [6:0]  VGA_Y;

  logic [2:0]  req1;
  logic [23:0] req1_x;
  logic [20:0] req1_y;
  logic [8:0]  req1_col;
  logic [2:0]  grant1, done1, col1;
  logic        busy1, plot1;
  logic [7:0]  vx1;
  logic [6:0]  vy1;

  rect_plot_arbiter #(.XDIM(XD), .YDIM(YD)) dut (
    .CLOCK_50(CLOCK_50), .Resetn(Resetn), .req(req), .req_x(req_x), .req_y(req_y),
    .req_col(req_col), .grant(grant), .done(done), .busy(busy), .VGA_X(VGA_X),
    .VGA_Y(VGA_Y), .VGA_COLOR(VGA_COLOR), .plot(plot)
  );

  rect_plot_arbiter #(.XDIM(1), .YDIM(1)) dut1 (
    .CLOCK_50(CLOCK_50), .Resetn(Resetn), .req(req1), .req_x(req1_x), .req_y(req1_y),
    .req_col(req1_col), .grant(grant1), .done(done1), .busy(busy1), .VGA_X(vx1),
    .VGA_Y(vy1), .VGA_COLOR(col1), .plot(plot1)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model: one job = pixels t=0..NPIX-1 then a done slot at t=NPIX.
  bit m_act;
  int m_t, m_last, m_win, m_bx, m_by, m_col, m_lx, m_ly, m_lc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit pix_visible(int t);
`ifdef RECT_CLIP_EN
    return ((m_bx + t % XD) <= 159) && ((m_by + t / XD) <= 119);
`else
    return 1'b1;
`endif
  endfunction

  task automatic model_edge();
    int w;
    if (!Resetn) begin
      m_act = 0; m_t = 0; m_last = 2; m_lx = 0; m_ly = 0; m_lc = 0;
    end else if (m_act) begin
      if (m_t < NPIX) begin
        m_lx = (m_bx + m_t % XD) % 256;
        m_ly = (m_by + m_t / XD) % 128;
        m_lc = m_col;
      end
      m_t++;
      if (m_t > NPIX) m_act = 0;
    end else if (req != 3'b000) begin
      w = -1;
      for (int k = 1; k <= 3; k++) begin
        int c;
        c = (m_last + k) % 3;
        if (w < 0 && req[c]) w = c;
      end
      m_win  = w;
      m_last = w;
      m_bx   = int'(req_x[8*w +: 8]);
      m_by   = int'(req_y[7*w +: 7]);
      m_col  = int'(req_col[3*w +: 3]);
      m_act  = 1;
      m_t    = 0;
    end
  endtask

  task automatic compare_all();
    int eg, ed, ep, ex, ey, ec;
    eg = 0; ed = 0; ep = 0; ex = m_lx; ey = m_ly; ec = m_lc;
    if (m_act && m_t < NPIX) begin
      ep = int'(pix_visible(m_t));
      ex = (m_bx + m_t % XD) % 256;
      ey = (m_by + m_t / XD) % 128;
      ec = m_col;
      if (m_t == 0) eg = 1 << m_win;
    end
    if (m_act && m_t == NPIX) ed = 1 << m_win;
    chk("sb_grant", 32'(grant), eg);
    chk("sb_done", 32'(done), ed);
    chk("sb_busy", 32'(busy), int'(m_act));
    chk("sb_plot", 32'(plot), ep);
    chk("sb_vga_x", 32'(VGA_X), ex);
    chk("sb_vga_y", 32'(VGA_Y), ey);
    chk("sb_vga_color", 32'(VGA_COLOR), ec);
  endtask

  task automatic tick();
    @(posedge CLOCK_50);
    model_edge();
    cyc++;
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    Resetn = 1'b0;
    req    = 3'b000;
    tick();
    tick();
    Resetn = 1'b1;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    chk("idle_timeout", 32'(busy), 0);
  endtask

  task automatic run_job(input logic [2:0] r);
    req = r;
    tick();
    req = 3'b000;
    wait_idle(NPIX + 10);
  endtask

  task automatic set_lanes();
    req_x   = {8'd120, 8'd60, 8'd10};
    req_y   = {7'd90, 7'd40, 7'd5};
    req_col = {3'd7, 3'd2, 3'd1};
  endtask

  typedef struct {
    logic [2:0] setup;
    logic [2:0] rq;
    logic [2:0] exp_grant;
    int         exp_x;
    int         exp_y;
    int         exp_col;
  } arb_vec_t;

  arb_vec_t tab[12];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int plots, maxx, bad, n, k;
    int gv[4];
    int gc[4];

    tab[0]  = '{3'b000, 3'b001, 3'b001, 10, 5, 1};
    tab[1]  = '{3'b000, 3'b111, 3'b001, 10, 5, 1};
    tab[2]  = '{3'b000, 3'b110, 3'b010, 60, 40, 2};
    tab[3]  = '{3'b000, 3'b100, 3'b100, 120, 90, 7};
    tab[4]  = '{3'b001, 3'b101, 3'b100, 120, 90, 7};
    tab[5]  = '{3'b001, 3'b011, 3'b010, 60, 40, 2};
    tab[6]  = '{3'b001, 3'b001, 3'b001, 10, 5, 1};
    tab[7]  = '{3'b010, 3'b111, 3'b100, 120, 90, 7};
    tab[8]  = '{3'b010, 3'b011, 3'b001, 10, 5, 1};
    tab[9]  = '{3'b010, 3'b010, 3'b010, 60, 40, 2};
    tab[10] = '{3'b100, 3'b110, 3'b010, 60, 40, 2};
    tab[11] = '{3'b100, 3'b111, 3'b001, 10, 5, 1};

    Resetn = 1'b0; req = '0; req_x = '0; req_y = '0; req_col = '0;
    req1 = '0; req1_x = '0; req1_y = '0; req1_col = '0;
    m_act = 0; m_t = 0; m_last = 2; m_win = 0; m_bx = 0; m_by = 0; m_col = 0;
    m_lx = 0; m_ly = 0; m_lc = 0;

    tick();
    tick();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_plot", 32'(plot), 0);
    chk("rst_vga_x", 32'(VGA_X), 0);
    chk("rst_vga_y", 32'(VGA_Y), 0);
    Resetn = 1'b1;

    // Arbitration table
    set_lanes();
    for (int i = 0; i < 12; i++) begin
      do_reset();
      if (tab[i].setup != 3'b000) run_job(tab[i].setup);
      req = tab[i].rq;
      tick();
      chk("tab_grant", 32'(grant), 32'(tab[i].exp_grant));
      chk("tab_x", 32'(VGA_X), tab[i].exp_x);
      chk("tab_y", 32'(VGA_Y), tab[i].exp_y);
      chk("tab_col", 32'(VGA_COLOR), tab[i].exp_col);
      chk("tab_plot", 32'(plot), 1);
      req = 3'b000;
      wait_idle(NPIX + 10);
    end

    // Full 10x10 rectangle at (30,30)
    do_reset();
    req_x = 24'd30; req_y = 21'd30; req_col = 9'b100;
    req = 3'b001;
    tick();
    chk("r29_grant", 32'(grant), 1);
    req = 3'b000;
    plots = 0;
    for (int i = 0; i < NPIX; i++) begin
      if (i > 0) tick();
      if (plot) plots++;
      chk("r29_x", 32'(VGA_X), 30 + i % 10);
      chk("r29_y", 32'(VGA_Y), 30 + i / 10);
    end
    chk("r29_plots", plots, 100);
    tick();
    chk("r29_done", 32'(done), 1);
    chk("r29_done_plot", 32'(plot), 0);
    tick();
    chk("r29_idle_busy", 32'(busy), 0);
    chk("r29_idle_done", 32'(done), 0);

    // Continuous 111 request: rotation and spacing
    do_reset();
    set_lanes();
    req = 3'b111;
    n = 0; k = 0;
    for (int i = 0; i < 4; i++) begin gv[i] = 0; gc[i] = 0; end
    while (n < 4 && k < 500) begin
      tick();
      k++;
      if (grant != 3'b000) begin
        gv[n] = int'(grant);
        gc[n] = cyc;
        n++;
      end
    end
    chk("rr_count", n, 4);
    chk("rr_g0", gv[0], 1);
    chk("rr_g1", gv[1], 2);
    chk("rr_g2", gv[2], 4);
    chk("rr_g3", gv[3], 1);
    for (int i = 1; i < 4; i++) chk("rr_gap", gc[i] - gc[i-1], NPIX + 2);
    req = 3'b000;
    wait_idle(NPIX + 10);

    // Frame-edge rectangle at (155,115)
    do_reset();
    req_x = 24'd155; req_y = 21'd115; req_col = 9'd5;
    req = 3'b001;
    tick();
    req = 3'b000;
    plots = 0; maxx = 0; bad = 0; n = 0;
    while (busy && n < 200) begin
      if (plot) begin
        plots++;
        if (VGA_X > maxx) maxx = VGA_X;
        if (VGA_X > 159 || VGA_Y > 119) bad++;
      end
      tick();
      n++;
    end
    chk("clip_cycles", n, NPIX + 1);
`ifdef RECT_CLIP_EN
    chk("clip_plots", plots, 25);
    chk("clip_out_of_frame", bad, 0);
    chk("clip_max_x", maxx, 159);
`else
    chk("clip_plots", plots, 100);
    chk("clip_max_x", maxx, 164);
`endif

    // Reset at pixel 50
    do_reset();
    req_x = 24'd30; req_y = 21'd30; req_col = 9'd3;
    req = 3'b001;
    tick();
    req = 3'b000;
    repeat (50) tick();
    chk("abort_pre_plot", 32'(plot), 1);
    Resetn = 1'b0;
    tick();
    chk("abort_plot", 32'(plot), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    Resetn = 1'b1;
    req = 3'b011;
    tick();
    chk("abort_regrant", 32'(grant), 1);
    req = 3'b000;
    wait_idle(NPIX + 10);

    // 1x1 instance
    do_reset();
    req1 = 3'b010;
    tick();
    chk("one_grant", 32'(grant1), 2);
    chk("one_plot", 32'(plot1), 1);
    chk("one_x", 32'(vx1), 0);
    chk("one_y", 32'(vy1), 0);
    req1 = 3'b000;
    tick();
    chk("one_done", 32'(done1), 2);
    chk("one_done_plot", 32'(plot1), 0);
    chk("one_done_grant", 32'(grant1), 0);
    tick();
    chk("one_idle_busy", 32'(busy1), 0);
    chk("one_idle_done", 32'(done1), 0);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 4000; i++) begin
      req     = ($urandom_range(0, 3) == 0) ? 3'b000 : 3'($urandom_range(0, 7));
      req_x   = 24'($urandom);
      req_y   = 21'($urandom);
      req_col = 9'($urandom);
      Resetn  = ($urandom_range(0, 399) != 0);
      tick();
    end
    Resetn = 1'b1;
    req = 3'b000;
    wait_idle(NPIX + 10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
